// File: rtl/data_sram_responder.sv
// Responder for the CPU data SRAM port: on-chip word RAM plus a small MMIO bank
// (LED, NUM, TIMER, SCRATCH). Read data is registered and appears one cycle after the request.
module data_sram_responder #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] MMIO_BASE  = 32'hbfaf_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic [31:0] num_data,
  output logic [31:0] timer_value
);

  // Handshake: there is no stall and no back-pressure. Every cycle with
  // data_sram_en=1 (outside reset) is an accepted access; we==0 reads, we!=0 writes.

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [13:0] OFF_LED     = 14'd0;
  localparam logic [13:0] OFF_NUM     = 14'd1;
  localparam logic [13:0] OFF_TIMER   = 14'd2;
  localparam logic [13:0] OFF_SCRATCH = 14'd3;

  logic [31:0] mem [DEPTH];
  logic [31:0] ram_q;
  logic        sel_ram_q;
  logic [31:0] mmio_q;
  logic [15:0] led_q;
  logic [31:0] num_q, timer_q, scratch_q;

  logic                  mmio_hit;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [13:0]           word_off;
  logic                  wr_en;
  logic [31:0]           mmio_rd;
  logic [15:0]           led_d;
  logic [31:0]           num_d, timer_d, scratch_d, timer_inc;
  logic [1:0]            addr_unused;

  assign mmio_hit    = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign ram_idx     = data_sram_addr[ADDR_WIDTH+1:2];
  assign word_off    = data_sram_addr[15:2];
  assign wr_en       = (data_sram_we != 4'b0000);
  assign addr_unused = data_sram_addr[1:0];
  assign timer_inc   = timer_q + 32'd1;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  we);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // Read-first: the returned word is always the pre-edge register value.
  always_comb begin
    mmio_rd = 32'h0;
    case (word_off)
      OFF_LED:     mmio_rd = {16'h0, led_q};
      OFF_NUM:     mmio_rd = num_q;
      OFF_TIMER:   mmio_rd = timer_q;
      OFF_SCRATCH: mmio_rd = scratch_q;
      default:     mmio_rd = 32'h0;
    endcase
  end

  always_comb begin
    led_d     = led_q;
    num_d     = num_q;
    scratch_d = scratch_q;
    timer_d   = timer_inc;
    if (data_sram_en && mmio_hit && wr_en) begin
      case (word_off)
        OFF_LED: begin
          led_d[7:0]  = data_sram_we[0] ? data_sram_wdata[7:0]  : led_q[7:0];
          led_d[15:8] = data_sram_we[1] ? data_sram_wdata[15:8] : led_q[15:8];
        end
        OFF_NUM:     num_d     = byte_merge(num_q, data_sram_wdata, data_sram_we);
        // Enabled bytes take the write, the rest keep counting.
        OFF_TIMER:   timer_d   = byte_merge(timer_inc, data_sram_wdata, data_sram_we);
        OFF_SCRATCH: scratch_d = byte_merge(scratch_q, data_sram_wdata, data_sram_we);
        default: ;
      endcase
    end
  end

  // Single-port synchronous RAM; contents survive reset, but reset-cycle requests are dropped.
  always_ff @(posedge clk) begin
    if (resetn && data_sram_en && !mmio_hit) begin
      ram_q <= mem[ram_idx];
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) mem[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sel_ram_q <= 1'b0;
      mmio_q    <= 32'h0;
      led_q     <= 16'h0;
      num_q     <= 32'h0;
      timer_q   <= 32'h0;
      scratch_q <= 32'h0;
    end else begin
      led_q     <= led_d;
      num_q     <= num_d;
      timer_q   <= timer_d;
      scratch_q <= scratch_d;
      if (data_sram_en) begin
        sel_ram_q <= !mmio_hit;
        if (mmio_hit) mmio_q <= mmio_rd;
      end
    end
  end

  // After reset sel_ram_q=0 and mmio_q=0, so rdata reads 0 until the first access.
  assign data_sram_rdata = sel_ram_q ? ram_q : mmio_q;
  assign led             = led_q;
  assign num_data        = num_q;
  assign timer_value     = timer_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder: directed scenarios followed by random
// traffic, all compared against a behavioural model of the RAM and MMIO bank.
module tb_data_sram_responder;

  localparam logic [31:0] MMIO = 32'hbfaf_0000;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [15:0] led;
  logic [31:0] num_data, timer_value;

  data_sram_responder #(.ADDR_WIDTH(12), .MMIO_BASE(MMIO)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .led             (led),
    .num_data        (num_data),
    .timer_value     (timer_value)
  );

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_mem [int];
  logic [15:0] m_led;
  logic [31:0] m_num, m_timer, m_scratch;
  logic [31:0] m_rdata;
  bit          m_known;

  // scoreboard
  logic [31:0] exp_q [$];
  bit          known_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] apply_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] we);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  // One clock edge of the specified behaviour, applied to the model.
  task automatic model_edge(input bit rst_n, input bit en, input logic [3:0] we,
                            input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] next_timer, old_v, wr_v;
    int idx;
    if (!rst_n) begin
      m_rdata = 0; m_known = 1; m_led = 0; m_num = 0; m_timer = 0; m_scratch = 0;
      return;
    end
    next_timer = m_timer + 1;
    if (en) begin
      if (addr[31:16] == MMIO[31:16]) begin
        case (addr[15:0] & 16'hfffc)
          16'h0000: old_v = {16'h0, m_led};
          16'h0004: old_v = m_num;
          16'h0008: old_v = m_timer;
          16'h000c: old_v = m_scratch;
          default:  old_v = 0;
        endcase
        m_rdata = old_v; m_known = 1;
        if (we != 0) begin
          case (addr[15:0] & 16'hfffc)
            16'h0000: begin
              wr_v  = apply_bytes({16'h0, m_led}, wdata, we);
              m_led = wr_v[15:0];
            end
            16'h0004: m_num      = apply_bytes(m_num, wdata, we);
            16'h0008: next_timer = apply_bytes(next_timer, wdata, we);
            16'h000c: m_scratch  = apply_bytes(m_scratch, wdata, we);
            default: ;
          endcase
        end
      end else begin
        idx = int'(addr[13:2]);
        if (m_mem.exists(idx)) begin
          m_rdata = m_mem[idx]; m_known = 1;
        end else begin
          m_rdata = 0; m_known = 0;
        end
        if (we == 4'hf) m_mem[idx] = wdata;
        else if (we != 0 && m_mem.exists(idx)) m_mem[idx] = apply_bytes(m_mem[idx], wdata, we);
      end
    end
    m_timer = next_timer;
  endtask

  // driver: one cycle, inputs applied 1 time unit after the previous edge
  task automatic step(input bit rst_n, input bit en, input logic [3:0] we,
                      input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] e;
    bit k;
    resetn = rst_n; data_sram_en = en; data_sram_we = we;
    data_sram_addr = addr; data_sram_wdata = wdata;
    model_edge(rst_n, en, we, addr, wdata);
    exp_q.push_back(m_rdata);
    known_q.push_back(m_known);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    k = known_q.pop_front();
    if (k) check("rdata", data_sram_rdata, e);
    check("led", {16'h0, led}, {16'h0, m_led});
    check("num", num_data, m_num);
    check("timer", timer_value, m_timer);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 4'h0, 32'h0, 32'h0);
  endtask

  logic [31:0] r_addr;
  logic [3:0]  r_we;

  initial begin
    m_known = 1;
    resetn = 0; data_sram_en = 0; data_sram_we = 0; data_sram_addr = 0; data_sram_wdata = 0;
    #1;
    step(0, 0, 4'h0, 32'h0, 32'h0);
    step(0, 0, 4'h0, 32'h0, 32'h0);
    check("reset_rdata", data_sram_rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);

    // timer: first post-reset edge read returns 0, next idle+read returns 2
    step(1, 1, 4'h0, MMIO + 32'h8, 32'h0);
    check("timer_first", data_sram_rdata, 32'h0);
    idle(1);
    step(1, 1, 4'h0, MMIO + 32'h8, 32'h0);
    check("timer_third", data_sram_rdata, 32'h2);

    // RAM write/read and hold while idle
    step(1, 1, 4'hf, 32'h100, 32'h1234_5678);
    step(1, 1, 4'h0, 32'h100, 32'h0);
    check("ram_rd", data_sram_rdata, 32'h1234_5678);
    idle(2);
    check("ram_hold", data_sram_rdata, 32'h1234_5678);

    // byte enables on RAM and LED
    step(1, 1, 4'hf, 32'h200, 32'haabb_ccdd);
    step(1, 1, 4'b0101, 32'h200, 32'h1122_3344);
    step(1, 1, 4'h0, 32'h200, 32'h0);
    check("ram_bytes", data_sram_rdata, 32'haa22_cc44);
    step(1, 1, 4'b0010, MMIO, 32'h0000_ab00);
    check("led_byte", {16'h0, led}, 32'h0000_ab00);
    step(1, 1, 4'hf, MMIO, 32'hffff_1234);
    step(1, 1, 4'h0, MMIO, 32'h0);
    check("led_upper0", data_sram_rdata, 32'h0000_1234);

    // read-first
    step(1, 1, 4'hf, 32'h300, 32'h1);
    step(1, 1, 4'hf, 32'h300, 32'h2);
    check("rf_old", data_sram_rdata, 32'h1);
    step(1, 1, 4'h0, 32'h300, 32'h0);
    check("rf_new", data_sram_rdata, 32'h2);

    // timer wrap and partial write
    step(1, 1, 4'hf, MMIO + 32'h8, 32'hffff_fffe);
    idle(1);
    step(1, 1, 4'h0, MMIO + 32'h8, 32'h0);
    check("timer_ff", data_sram_rdata, 32'hffff_ffff);
    step(1, 1, 4'h0, MMIO + 32'h8, 32'h0);
    check("timer_wrap", data_sram_rdata, 32'h0);
    step(1, 1, 4'b0001, MMIO + 32'h8, 32'h0000_00aa);
    check("timer_part", timer_value, 32'h0000_00aa);
    idle(1);
    check("timer_count", timer_value, 32'h0000_00ab);

    // aliasing and unmapped MMIO
    step(1, 1, 4'hf, 32'h0000_0010, 32'h5);
    step(1, 1, 4'h0, 32'h0001_0010, 32'h0);
    check("alias", data_sram_rdata, 32'h5);
    step(1, 1, 4'hf, MMIO + 32'h20, 32'hdead_beef);
    step(1, 1, 4'h0, MMIO + 32'h20, 32'h0);
    check("unmapped", data_sram_rdata, 32'h0);

    // reset mid-operation
    step(1, 1, 4'hf, MMIO + 32'h4, 32'h0000_1234);
    check("num_set", num_data, 32'h0000_1234);
    step(0, 1, 4'hf, MMIO + 32'h4, 32'h9999_9999);
    check("rst_num", num_data, 32'h0);
    check("rst_rdata", data_sram_rdata, 32'h0);
    check("rst_timer", timer_value, 32'h0);
    step(1, 1, 4'h0, 32'h100, 32'h0);
    check("ram_kept", data_sram_rdata, 32'h1234_5678);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        r_addr = MMIO | (32'($urandom_range(0, 9)) << 2) | 32'($urandom_range(0, 3));
      end else begin
        r_addr = $urandom;
        r_addr[31] = 1'b0;
        r_addr[13:2] = 12'($urandom_range(0, 15));
      end
      r_we = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0), r_we, r_addr, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
